// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the product accumulator slice: the controller state
// encoding, fixed product/output byte widths and default accumulator sizing.
// No ports.
// -----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DRAIN = 2'b10
    } state_e;

    localparam int PROD_W    = 8;
    localparam int OUT_W     = 8;
    localparam int ACC_W_DEF = 16;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/mult_accumulator_if.sv
// -----------------------------------------------------------------------------
// mult_accumulator_if
// Groups the two streaming handshakes of the accumulator:
//   prod_i / prod_valid / prod_ready  - product input from the array multiplier
//   out_data / out_valid / out_ready  - byte-serial drain output
// master: the side that supplies products and consumes drain bytes.
// slave : the accumulator itself.
// -----------------------------------------------------------------------------
interface mult_accumulator_if;
    import mult_pkg::*;

    logic [PROD_W-1:0] prod_i;
    logic              prod_valid;
    logic              prod_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output prod_i,
        output prod_valid,
        input  prod_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  prod_i,
        input  prod_valid,
        output prod_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

endinterface

// File: rtl/acc_byte_serializer.sv
// -----------------------------------------------------------------------------
// acc_byte_serializer
// Captures an ACC_W-bit snapshot on start_i and presents it LSB-first, one
// byte per out_ready handshake, on registered out_data_o/out_valid_o.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        load snap_i and present byte 0 next cycle
//   abort_i        drop the current drain immediately (wins over start_i)
//   snap_i         value to drain
//   out_ready_i    downstream accepts the current byte
//   out_data_o     current byte
//   out_valid_o    out_data_o is valid
//   done_o         handshake of the final byte happens this cycle
// -----------------------------------------------------------------------------
module acc_byte_serializer
    import mult_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [ACC_W-1:0] snap_i,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_valid_o,
    output logic             done_o
);

    localparam int NBYTES = ACC_W / OUT_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [ACC_W-1:0] snap_q;
    logic [IDX_W-1:0] idx_q;
    logic [OUT_W-1:0] data_q;
    logic             valid_q;
    logic             hs;
    logic             last;

    function automatic logic [OUT_W-1:0] byte_at(input logic [ACC_W-1:0] w,
                                                  input logic [IDX_W-1:0] i);
        return w[OUT_W*int'(i) +: OUT_W];
    endfunction

    assign hs     = valid_q & out_ready_i;
    assign last   = (idx_q == IDX_W'(NBYTES - 1));
    assign done_o = hs & last & ~abort_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (abort_i) begin
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (start_i) begin
            snap_q  <= snap_i;
            idx_q   <= '0;
            data_q  <= byte_at(snap_i, '0);
            valid_q <= 1'b1;
        end else if (hs) begin
            if (last) begin
                idx_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                // Pre-load the next byte so it is registered when valid stays high.
                idx_q  <= idx_q + IDX_W'(1);
                data_q <= byte_at(snap_q, idx_q + IDX_W'(1));
            end
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

endmodule

// File: rtl/mult_accumulator.sv
// -----------------------------------------------------------------------------
// mult_accumulator
// Sums a stream of 8-bit unsigned products into an ACC_W-bit accumulator,
// counts accepted terms (saturating) and flags wrap-around (sticky). A dump
// request drains the sum LSB-first as bytes, after which all state clears.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         product input and drain output handshakes (slave side)
//   clear       synchronous clear of accumulator, count, overflow and drain
//   dump        request a drain of the current sum (level-sampled)
//   term_cnt    accepted products, saturating at 2^CNT_W-1
//   overflow    sticky: accumulator wrapped past 2^ACC_W-1
//   busy        high while draining
// -----------------------------------------------------------------------------
module mult_accumulator
    import mult_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_accumulator_if.slave bus,
    input  logic             clear,
    input  logic             dump,
    output logic [CNT_W-1:0] term_cnt,
    output logic             overflow,
    output logic             busy
);

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic             accept;
    logic             start;
    logic             drain_done;
    logic [ACC_W:0]   sum_d;
    logic [ACC_W-1:0] snap_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // rst_n gates ready so nothing is offered while reset is held.
    assign bus.prod_ready = rst_n & (state_q != DRAIN) & ~clear;
    assign accept         = bus.prod_valid & bus.prod_ready;

    // One extra bit keeps the carry that feeds the sticky overflow flag.
    assign sum_d  = {1'b0, acc_q} + (ACC_W+1)'(bus.prod_i);
    // A product accepted in the dump cycle is part of the drained value.
    assign snap_d = accept ? sum_d[ACC_W-1:0] : acc_q;
    assign start  = dump & ~clear & (state_q != DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_q   <= sum_d[ACC_W-1:0];
                        ovf_q   <= ovf_q | sum_d[ACC_W];
                        cnt_q   <= sat_inc(cnt_q);
                        state_q <= ACCUM;
                    end
                    if (dump) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    acc_byte_serializer #(
        .ACC_W(ACC_W)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .abort_i    (clear),
        .snap_i     (snap_d),
        .out_ready_i(bus.out_ready),
        .out_data_o (bus.out_data),
        .out_valid_o(bus.out_valid),
        .done_o     (drain_done)
    );

    assign term_cnt = cnt_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == DRAIN);

endmodule

// File: tb/tb_mult_accumulator.sv
module tb_mult_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       dump = 1'b0;
    logic [3:0] term_cnt;
    logic       overflow;
    logic       busy;

    mult_accumulator_if bus ();

    mult_accumulator #(
        .ACC_W(16),
        .CNT_W(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .clear   (clear),
        .dump    (dump),
        .term_cnt(term_cnt),
        .overflow(overflow),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    logic       hold_prev = 1'b0;
    logic       clear_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push16(input logic [15:0] v);
        exp_q.push_back(v[7:0]);
        exp_q.push_back(v[15:8]);
    endtask

    task automatic accept(input logic [7:0] v);
        bus.prod_valid = 1'b1;
        bus.prod_i     = v;
        tick();
        bus.prod_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("drain_done", int'(busy), 0);
    endtask

    task automatic do_dump(input logic [15:0] v);
        push16(v);
        dump = 1'b1;
        tick();
        dump = 1'b0;
        wait_idle();
    endtask

    // Scoreboard monitor: pops an expected byte on every drain handshake and
    // checks that a stalled byte stays put until it is taken.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !clear) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", int'(bus.out_data), -1);
            end else begin
                chk("drain_byte", int'(bus.out_data), int'(exp_q.pop_front()));
            end
        end
        if (rst_n && hold_prev && !clear_prev) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_data", int'(bus.out_data), int'(data_prev));
        end
        hold_prev  = rst_n && bus.out_valid && !bus.out_ready;
        data_prev  = bus.out_data;
        clear_prev = clear;
    end

    initial begin
        bus.prod_i     = 8'h00;
        bus.prod_valid = 1'b0;
        bus.out_ready  = 1'b1;

        // Reset and idle
        repeat (3) tick();
        chk("rst_prod_ready", int'(bus.prod_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_term_cnt", int'(term_cnt), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_prod_ready", int'(bus.prod_ready), 1);

        // Asynchronous reset in the middle of a drain
        accept(8'd7);
        bus.out_ready = 1'b0;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        chk("pre_arst_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_term_cnt", int'(term_cnt), 0);
        chk("arst_prod_ready", int'(bus.prod_ready), 0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();

        // Two-term sum: 225 + 225 = 0x01C2
        accept(8'd225);
        accept(8'd225);
        chk("two_term_cnt", int'(term_cnt), 2);
        do_dump(16'h01C2);
        chk("two_post_cnt", int'(term_cnt), 0);
        chk("two_post_ovf", int'(overflow), 0);
        // Dump from IDLE drains zeros, which also shows acc was cleared
        do_dump(16'h0000);

        // Backpressure
        accept(8'h40);
        bus.out_ready = 1'b0;
        push16(16'h0040);
        dump = 1'b1;
        tick();
        dump = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.prod_valid = 1'b1;
            bus.prod_i     = 8'h55;
            #1;
            chk("bp_prod_ready", int'(bus.prod_ready), 0);
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_out_data", int'(bus.out_data), 8'h40);
            tick();
        end
        bus.prod_valid = 1'b0;
        chk("bp_term_cnt", int'(term_cnt), 1);
        bus.out_ready = 1'b1;
        wait_idle();

        // Overflow and saturation: 292 * 225 = 65700 = 0x100A4
        bus.prod_valid = 1'b1;
        bus.prod_i     = 8'd225;
        repeat (292) tick();
        bus.prod_valid = 1'b0;
        chk("ovf_term_cnt", int'(term_cnt), 15);
        chk("ovf_flag", int'(overflow), 1);
        do_dump(16'h00A4);
        chk("ovf_cleared", int'(overflow), 0);

        // Accept and dump in the same cycle: 5 + 10
        accept(8'd5);
        bus.prod_valid = 1'b1;
        bus.prod_i     = 8'd10;
        dump = 1'b1;
        push16(16'h000F);
        tick();
        bus.prod_valid = 1'b0;
        dump = 1'b0;
        wait_idle();
        chk("sim_term_cnt", int'(term_cnt), 0);

        // Clear together with a product
        accept(8'd3);
        clear = 1'b1;
        bus.prod_valid = 1'b1;
        bus.prod_i     = 8'd9;
        #1;
        chk("clr_prod_ready", int'(bus.prod_ready), 0);
        tick();
        clear = 1'b0;
        bus.prod_valid = 1'b0;
        chk("clr_term_cnt", int'(term_cnt), 0);
        do_dump(16'h0000);

        // Clear mid-drain: 18 * 255 + 70 = 0x1234
        bus.prod_valid = 1'b1;
        bus.prod_i     = 8'd255;
        repeat (18) tick();
        bus.prod_i     = 8'd70;
        tick();
        bus.prod_valid = 1'b0;
        chk("mid_ovf", int'(overflow), 0);
        bus.out_ready = 1'b0;
        exp_q.push_back(8'h34);
        dump = 1'b1;
        tick();
        dump = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("mid_out_valid", int'(bus.out_valid), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_term_cnt", int'(term_cnt), 0);
        chk("mid_overflow", int'(overflow), 0);
        bus.out_ready = 1'b1;
        do_dump(16'h0000);

        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
